alu_flag_wb: RTL and testbench
==============================

ALU_FLAG_WB -- requirements
Module: alu_flag_wb

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of the result and write-back path.
REQ-002 SHALL have parameter DEPTH, default 2: number of buffer entries.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and reset_n.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: ALU stage presents an operation.
REQ-007 Port in_ready, output, 1: buffer can accept; equals (count < DEPTH).
REQ-008 Port in_op, input, 8: ALU operation control byte, [7:4] class, [3:0] sub-op.
REQ-009 Port in_result, input, WIDTH: ALU result.
REQ-010 Port in_dest, input, 4: destination register index.
REQ-011 Port in_flags, input, 5: ALU flags {C,L,F,Z,N}, where F = overflow.
REQ-012 Port rf_ready, output... correction: input, 1: register file accepts the write this cycle.
REQ-013 Ports rf_we (1), rf_waddr (4), rf_wdata (WIDTH), outputs: register-file write port, driven from the head entry.
REQ-014 Port cond, input, 4: condition code to evaluate; cond_true, output, 1: evaluation result.
REQ-015 Port psr, output, 5: committed flags {C,L,F,Z,N}; flags_pending, output, 1: a buffered entry will update flags.

Function
REQ-016 SHALL push {op, result, dest, flags} into a FIFO of DEPTH entries on each rising edge where in_valid && in_ready.
REQ-017 SHALL classify each entry by op into write-enable (W) and flag mask (M):
- op 0x05, 0x09, class 0x5, class 0x9: W=1, M={C,F,N}.
- op 0x06, 0x07, class 0x6: W=1, M={C}.
- op 0x0B or class 0xB: W=0, M={L,Z,N}.
- ops 0x01/02/03/0D/0E, classes 0x1/0x2/0x3/0xD/0xF, class 0x8 sub-ops 0x0-0x4 and 0x6, op 0x40 (load): W=1, M={}.
- all other ops, including 0x44, 0x85, class 0xC and 0x4C/0x48: W=0, M={}.
REQ-018 rf_we SHALL be 1 exactly when the head entry is valid and W=1; rf_waddr and rf_wdata SHALL equal the head dest and result; both are 0 when rf_we=0.
REQ-019 The head SHALL retire on a rising edge when valid and (W=0 or rf_ready=1); an entry is never dropped or duplicated.
REQ-020 On retire, psr bits selected by M SHALL load from the head flags; unselected bits hold.
REQ-021 Latency: an entry accepted at edge k drives rf_we during cycle k+1 if it is at the head; minimum acceptance-to-retire is one edge.
REQ-022 A simultaneous push and retire SHALL keep count unchanged; when count==DEPTH, in_ready=0 even if the head retires that cycle.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 flags_pending SHALL be 1 when any valid entry has non-empty M.
REQ-025 cond_true SHALL be a combinational function of the committed psr only, with no bypass from the buffer:
- EQ 0:Z, NE 1:!Z, CS 2:C, CC 3:!C, HI 4:L, LS 5:!L, GT 6:N, LE 7:!N, FS 8:F, FC 9:!F.
- LO 10:!L&!Z, HS 11:L|Z, LT 12:!N&!Z, GE 13:N|Z, UC 14:1, never 15:0.

Reset
REQ-026 While reset_n=0, SHALL set count=0, pointers=0, psr=0; outputs SHALL be rf_we=0, rf_waddr=0, rf_wdata=0, flags_pending=0, in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries with no write and no flag update.
REQ-028 The first push SHALL be accepted on the first rising edge after reset_n rises.

Verification
REQ-029 ADD op 0x05, result 0x1234, dest 3, flags C=1,F=1,N=0, rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=0x1234; after the edge psr C=1, F=1, N=0; L and Z unchanged.
REQ-030 CMPI op 0xB0 with Z=1,L=0 -> rf_we stays 0; entry retires without rf_ready; cond=0 gives cond_true=1 after the retire edge and 0 before it.
REQ-031 rf_ready=0 with 3 back-to-back ANDs -> two accepted, in_ready=0, third held; raising rf_ready drains in order with dest order preserved and no loss.
REQ-032 Full buffer with simultaneous pop and valid input -> in_ready=0, no push that edge; push on the following edge; count wraps correctly through 5+ cycles.
REQ-033 Assert reset_n=0 with 2 entries pending and flags_pending=1 -> rf_we=0, psr=0, in_ready=1 immediately; no write is observed after release.
REQ-034 Sweep cond 0-15 over all 32 psr values -> cond_true matches the REQ-025 table.

Source files
------------

// File: rtl/alu_flag_wb.sv
// ALU write-back buffer: queues ALU results, drains them into the register file
// in order, and commits the flag subset each operation class is allowed to update.
module alu_flag_wb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_dest,
  input  logic [4:0]       in_flags,
  input  logic             rf_ready,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic [4:0]       psr,
  output logic             flags_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Flag masks, bit order {C,L,F,Z,N}
  localparam logic [4:0] M_CFN = 5'b10101;
  localparam logic [4:0] M_C   = 5'b10000;
  localparam logic [4:0] M_LZN = 5'b01011;

  // Returns {W, M}; the write enable and flag mask are decoded once at push time.
  function automatic logic [5:0] classify(input logic [7:0] op);
    logic [3:0] cls;
    logic [3:0] sub;
    cls = op[7:4];
    sub = op[3:0];
    if (op == 8'h05 || op == 8'h09 || cls == 4'h5 || cls == 4'h9)
      classify = {1'b1, M_CFN};
    else if (op == 8'h06 || op == 8'h07 || cls == 4'h6)
      classify = {1'b1, M_C};
    else if (op == 8'h0B || cls == 4'hB)
      classify = {1'b0, M_LZN};
    else if (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h0D || op == 8'h0E ||
             cls == 4'h1 || cls == 4'h2 || cls == 4'h3 || cls == 4'hD || cls == 4'hF ||
             (cls == 4'h8 && (sub <= 4'h4 || sub == 4'h6)) || op == 8'h40)
      classify = {1'b1, 5'b00000};
    else
      classify = 6'b000000;
  endfunction

  logic [WIDTH-1:0] r_res [DEPTH];
  logic [3:0]       r_dst [DEPTH];
  logic [4:0]       r_flg [DEPTH];
  logic [4:0]       r_msk [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_wen;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [4:0]       r_psr;

  logic [5:0] w_cls;
  logic       w_push;
  logic       w_pop;
  logic       w_head_vld;
  logic       w_head_we;
  logic [4:0] w_head_msk;

  assign w_cls      = classify(in_op);
  assign in_ready   = (r_count < FULL);
  assign w_push     = in_valid && in_ready;
  assign w_head_vld = r_vld[r_rd_ptr];
  assign w_head_we  = r_wen[r_rd_ptr];
  assign w_head_msk = r_msk[r_rd_ptr];
  assign w_pop      = w_head_vld && (!w_head_we || rf_ready);

  assign rf_we    = w_head_vld && w_head_we;
  assign rf_waddr = rf_we ? r_dst[r_rd_ptr] : 4'd0;
  assign rf_wdata = rf_we ? r_res[r_rd_ptr] : '0;
  assign psr      = r_psr;

  always_comb begin
    flags_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && (r_msk[i] != 5'b00000)) flags_pending = 1'b1;
  end

  // Push and pop never address the same slot: a push into an empty buffer has no valid head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_psr    <= 5'b00000;
      r_vld    <= '0;
      r_wen    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
        r_dst[i] <= 4'd0;
        r_flg[i] <= 5'd0;
        r_msk[i] <= 5'd0;
      end
    end else begin
      if (w_push) begin
        r_res[r_wr_ptr] <= in_result;
        r_dst[r_wr_ptr] <= in_dest;
        r_flg[r_wr_ptr] <= in_flags;
        r_msk[r_wr_ptr] <= w_cls[4:0];
        r_wen[r_wr_ptr] <= w_cls[5];
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_psr           <= (r_psr & ~w_head_msk) | (r_flg[r_rd_ptr] & w_head_msk);
        r_rd_ptr        <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_comb begin
    case (cond)
      4'd0:    cond_true = r_psr[1];
      4'd1:    cond_true = !r_psr[1];
      4'd2:    cond_true = r_psr[4];
      4'd3:    cond_true = !r_psr[4];
      4'd4:    cond_true = r_psr[3];
      4'd5:    cond_true = !r_psr[3];
      4'd6:    cond_true = r_psr[0];
      4'd7:    cond_true = !r_psr[0];
      4'd8:    cond_true = r_psr[2];
      4'd9:    cond_true = !r_psr[2];
      4'd10:   cond_true = !r_psr[3] && !r_psr[1];
      4'd11:   cond_true = r_psr[3] || r_psr[1];
      4'd12:   cond_true = !r_psr[0] && !r_psr[1];
      4'd13:   cond_true = r_psr[0] || r_psr[1];
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Directed bench for alu_flag_wb: op-class table, back-pressure, full-buffer,
// reset discard and condition-code sweep, with an in-order write scoreboard.
module tb_alu_flag_wb;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_op;
  logic [WIDTH-1:0] in_result;
  logic [3:0]       in_dest;
  logic [4:0]       in_flags;
  logic             rf_ready;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [3:0]       cond;
  logic             cond_true;
  logic [4:0]       psr;
  logic             flags_pending;

  alu_flag_wb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_dest(in_dest), .in_flags(in_flags),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cond(cond), .cond_true(cond_true), .psr(psr), .flags_pending(flags_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic [7:0]  op;
    logic [15:0] res;
    logic [3:0]  dest;
    logic [4:0]  flags;
    logic        exp_we;
    logic [4:0]  exp_m;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [15:0] res,
                        input logic [3:0] dest, input logic [4:0] fl);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_dest   = dest;
    in_flags  = fl;
  endtask

  function automatic logic cond_model(input logic [4:0] p, input logic [3:0] c);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = p;
    case (c)
      4'd0: return fz;          4'd1: return !fz;
      4'd2: return fc;          4'd3: return !fc;
      4'd4: return fl;          4'd5: return !fl;
      4'd6: return fn;          4'd7: return !fn;
      4'd8: return ff;          4'd9: return !ff;
      4'd10: return !fl && !fz; 4'd11: return fl || fz;
      4'd12: return !fn && !fz; 4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Every register-file write that completes must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && rf_we && rf_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got %0h want none", {rf_waddr, rf_wdata});
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL wr_order: got %0h want %0h", {rf_waddr, rf_wdata}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_psr;
    logic [15:0] rdy_pat;
    int m_cnt;
    int n_acc;
    logic exp_rdy, exp_pop;

    vecs[0]  = '{8'h05, 16'h1234, 4'd3,  5'b11110, 1'b1, 5'b10101};
    vecs[1]  = '{8'h53, 16'hBEEF, 4'd5,  5'b01011, 1'b1, 5'b10101};
    vecs[2]  = '{8'h06, 16'h0006, 4'd6,  5'b10000, 1'b1, 5'b10000};
    vecs[3]  = '{8'h6A, 16'h6A6A, 4'd7,  5'b01111, 1'b1, 5'b10000};
    vecs[4]  = '{8'h0B, 16'h0B0B, 4'd8,  5'b11111, 1'b0, 5'b01011};
    vecs[5]  = '{8'hB7, 16'hB7B7, 4'd9,  5'b00100, 1'b0, 5'b01011};
    vecs[6]  = '{8'h01, 16'h0101, 4'd1,  5'b11111, 1'b1, 5'b00000};
    vecs[7]  = '{8'h2F, 16'h2F2F, 4'd2,  5'b11111, 1'b1, 5'b00000};
    vecs[8]  = '{8'hD5, 16'hD5D5, 4'd13, 5'b11111, 1'b1, 5'b00000};
    vecs[9]  = '{8'hF0, 16'hF0F0, 4'd15, 5'b11111, 1'b1, 5'b00000};
    vecs[10] = '{8'h84, 16'h8484, 4'd8,  5'b11111, 1'b1, 5'b00000};
    vecs[11] = '{8'h86, 16'h8686, 4'd9,  5'b11111, 1'b1, 5'b00000};
    vecs[12] = '{8'h85, 16'h8585, 4'd10, 5'b11111, 1'b0, 5'b00000};
    vecs[13] = '{8'h40, 16'h4040, 4'd4,  5'b11111, 1'b1, 5'b00000};
    vecs[14] = '{8'h44, 16'h4444, 4'd4,  5'b11111, 1'b0, 5'b00000};
    vecs[15] = '{8'h4C, 16'h4C4C, 4'd4,  5'b11111, 1'b0, 5'b00000};
    vecs[16] = '{8'hC3, 16'hC3C3, 4'd12, 5'b11111, 1'b0, 5'b00000};
    vecs[17] = '{8'h09, 16'h0909, 4'd10, 5'b00101, 1'b1, 5'b10101};
    vecs[18] = '{8'h97, 16'h9797, 4'd11, 5'b10000, 1'b1, 5'b10101};
    vecs[19] = '{8'h07, 16'h0707, 4'd12, 5'b00000, 1'b1, 5'b10000};
    vecs[20] = '{8'h0E, 16'h0E0E, 4'd14, 5'b11111, 1'b1, 5'b00000};
    vecs[21] = '{8'hA0, 16'hA0A0, 4'd3,  5'b11111, 1'b0, 5'b00000};
    vecs[22] = '{8'h87, 16'h8787, 4'd3,  5'b11111, 1'b0, 5'b00000};
    vecs[23] = '{8'h48, 16'h4848, 4'd3,  5'b11111, 1'b0, 5'b00000};

    // clock/reset
    reset_n = 1'b0; in_valid = 1'b0; in_op = 8'h00; in_result = '0;
    in_dest = 4'd0; in_flags = 5'd0; rf_ready = 1'b1; cond = 4'd0;
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", 32'(rf_wdata), 32'd0);
    check("rst_pending", 32'(flags_pending), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_psr", 32'(psr), 32'd0);
    #10 reset_n = 1'b1;
    tick();

    // op-class table, one operation at a time
    exp_psr = 5'b00000;
    for (int i = 0; i < 24; i++) begin
      set_in(vecs[i].op, vecs[i].res, vecs[i].dest, vecs[i].flags);
      if (vecs[i].exp_we) exp_q.push_back({vecs[i].dest, vecs[i].res});
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      check($sformatf("v%0d_waddr", i), 32'(rf_waddr), vecs[i].exp_we ? 32'(vecs[i].dest) : 32'd0);
      check($sformatf("v%0d_wdata", i), 32'(rf_wdata), vecs[i].exp_we ? 32'(vecs[i].res) : 32'd0);
      check($sformatf("v%0d_pending", i), 32'(flags_pending), 32'(vecs[i].exp_m != 5'd0));
      check($sformatf("v%0d_psr_pre", i), 32'(psr), 32'(exp_psr));
      exp_psr = (exp_psr & ~vecs[i].exp_m) | (vecs[i].flags & vecs[i].exp_m);
      tick();
      check($sformatf("v%0d_psr", i), 32'(psr), 32'(exp_psr));
      check($sformatf("v%0d_empty", i), 32'({in_ready, rf_we}), 32'b10);
    end

    // compare-class op retires without rf_ready; flags visible only after retire
    rf_ready = 1'b0;
    cond = 4'd0;
    #1 check("cmpi_cond_before_push", 32'(cond_true), 32'd0);
    set_in(8'hB0, 16'h00B0, 4'd0, 5'b00010);
    tick();
    in_valid = 1'b0;
    check("cmpi_no_we", 32'(rf_we), 32'd0);
    check("cmpi_pending", 32'(flags_pending), 32'd1);
    check("cmpi_cond_before", 32'(cond_true), 32'd0);
    exp_psr = (exp_psr & ~5'b01011) | 5'b00010;
    tick();
    check("cmpi_cond_after", 32'(cond_true), 32'd1);
    check("cmpi_psr", 32'(psr), 32'(exp_psr));
    check("cmpi_retired", 32'(in_ready), 32'd1);

    // back-pressure: three ANDs against a stalled register file
    exp_q.push_back({4'd1, 16'hAA01});
    exp_q.push_back({4'd2, 16'hAA02});
    exp_q.push_back({4'd3, 16'hAA03});
    set_in(8'h11, 16'hAA01, 4'd1, 5'd0);
    check("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    set_in(8'h11, 16'hAA02, 4'd2, 5'd0);
    check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    set_in(8'h11, 16'hAA03, 4'd3, 5'd0);
    check("bp_full", 32'(in_ready), 32'd0);
    tick();
    check("bp_held", 32'(in_ready), 32'd0);
    check("bp_head", 32'({rf_we, rf_waddr}), 32'h11);
    rf_ready = 1'b1;
    check("bp_full_pop", 32'(in_ready), 32'd0);
    tick();
    check("bp_after_pop", 32'(in_ready), 32'd1);
    check("bp_head2", 32'(rf_waddr), 32'd2);
    tick();
    in_valid = 1'b0;
    check("bp_head3", 32'(rf_waddr), 32'd3);
    tick();
    check("bp_drained", 32'({in_ready, rf_we}), 32'b10);

    // continuous traffic with a varying rf_ready pattern to wrap the pointers
    rdy_pat = 16'b1011_0010_1110_0110;
    m_cnt = 0;
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      rf_ready = rdy_pat[c];
      set_in(8'h2A, 16'hC000 + 16'(n_acc), 4'(n_acc), 5'd0);
      exp_rdy = (m_cnt < DEPTH);
      exp_pop = (m_cnt > 0) && rdy_pat[c];
      check($sformatf("st%0d_ready", c), 32'(in_ready), 32'(exp_rdy));
      check($sformatf("st%0d_we", c), 32'(rf_we), 32'(m_cnt > 0));
      if (exp_rdy) begin
        exp_q.push_back({4'(n_acc), 16'hC000 + 16'(n_acc)});
        n_acc++;
      end
      tick();
      m_cnt = m_cnt + (exp_rdy ? 1 : 0) - (exp_pop ? 1 : 0);
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    for (int c = 0; c < DEPTH; c++) tick();
    check("st_drained", 32'(exp_q.size()), 32'd0);

    // mid-operation reset discards pending entries
    rf_ready = 1'b0;
    set_in(8'h05, 16'hDEAD, 4'd1, 5'b11111);
    tick();
    set_in(8'h06, 16'hBEEF, 4'd2, 5'b11111);
    tick();
    in_valid = 1'b0;
    check("rr_pending", 32'(flags_pending), 32'd1);
    check("rr_full", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rr_we", 32'(rf_we), 32'd0);
    check("rr_psr", 32'(psr), 32'd0);
    check("rr_ready", 32'(in_ready), 32'd1);
    check("rr_pending_clr", 32'(flags_pending), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rf_ready = 1'b1;
    exp_psr = 5'b00000;

    // first push accepted on the first edge after release
    set_in(8'h01, 16'h5555, 4'd5, 5'd0);
    exp_q.push_back({4'd5, 16'h5555});
    tick();
    in_valid = 1'b0;
    check("post_rst_we", 32'({rf_we, rf_waddr}), 32'h15);
    tick();
    tick();
    check("post_rst_psr", 32'(psr), 32'd0);
    check("post_rst_idle", 32'(rf_we), 32'd0);

    // condition sweep over every psr value
    for (int v = 0; v < 32; v++) begin
      set_in(8'h0B, 16'h0000, 4'd0, 5'(v));
      tick();
      set_in(8'h05, 16'(v), 4'd0, 5'(v));
      exp_q.push_back({4'd0, 16'(v)});
      tick();
      in_valid = 1'b0;
      tick();
      check($sformatf("sw%0d_psr", v), 32'(psr), 32'(v));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        check($sformatf("sw%0d_c%0d", v, c), 32'(cond_true), 32'(cond_model(5'(v), 4'(c))));
      end
    end

    tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
